// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative HI/LO multiply/divide unit for a 5-stage pipeline. It computes
//   MULT/MULTU with a radix-2 shift-add and DIV/DIVU with a restoring
//   shift-subtract, one step per clock. Signed operations run on magnitudes
//   and get their signs fixed up in a final cycle before HI/LO commit.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        EX-stage mult/div instruction present
//   i_op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_operand_a    rs (multiplicand / dividend)
//   i_operand_b    rt (multiplier / divisor)
//   i_hi_read      mfhi in EX
//   i_lo_read      mflo in EX
//   i_write_hi     mthi in EX
//   i_write_lo     mtlo in EX
//   i_write_data   mthi/mtlo source value
//   o_hi, o_lo     architectural HI/LO registers
//   o_busy         operation in progress
//   o_stall        freeze IF/ID/EX (combinational)
//   o_done         one-cycle pulse in the cycle after HI/LO commit
//   o_div_by_zero  pulses with o_done when a divide had a zero divisor
// ---------------------------------------------------------------------------
module muldiv_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic        i_hi_read,
  input  logic        i_lo_read,
  input  logic        i_write_hi,
  input  logic        i_write_lo,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_div_by_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_FIXUP = 2'd3;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;          // |A| for signed ops, raw A otherwise
  logic [31:0] r_b;          // |B| for signed ops, raw B otherwise
  logic        r_sa;
  logic        r_sb;
  logic [63:0] r_acc;        // product accumulator {upper, multiplier}
  logic [32:0] r_rem;        // partial remainder
  logic [31:0] r_quo;        // dividend shifts out as quotient shifts in
  logic        r_dbz;
  logic        r_fix_wait;   // extra FIXUP cycle on divide-by-zero
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_dbz_flag;

  // Operand magnitudes at issue; op[0] == 0 marks the signed variants.
  logic        w_signed_in;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  assign w_signed_in = ~i_op[0];
  assign w_abs_a = (w_signed_in && i_operand_a[31]) ? (~i_operand_a + 32'd1) : i_operand_a;
  assign w_abs_b = (w_signed_in && i_operand_b[31]) ? (~i_operand_b + 32'd1) : i_operand_b;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set; the 33rd bit keeps the carry for the shift.
  logic [32:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_a : 32'd0)};

  // Divide step: shift in the next dividend bit and trial-subtract; a set
  // bit 33 means the subtraction went negative and the remainder is restored.
  logic [32:0] w_shifted;
  logic [33:0] w_trial;
  assign w_shifted = {r_rem[31:0], r_quo[31]};
  assign w_trial   = {1'b0, w_shifted} - {2'b00, r_b};

  // Sign fixup: product and quotient negative when signs differ, remainder
  // follows the dividend.
  logic        w_neg_res;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  assign w_neg_res  = ~r_op[0] & (r_sa ^ r_sb);
  assign w_prod_fix = w_neg_res ? (~r_acc + 64'd1) : r_acc;
  assign w_quo_fix  = w_neg_res ? (~r_quo + 32'd1) : r_quo;
  assign w_rem_fix  = (~r_op[0] & r_sa) ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  // NOTE: every register, datapath included, is reset so that work cut off
  // by reset can never leak into a later commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_op       <= 2'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_acc      <= 64'd0;
      r_rem      <= 33'd0;
      r_quo      <= 32'd0;
      r_dbz      <= 1'b0;
      r_fix_wait <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
      r_dbz_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values regardless of statement order.
      r_done     <= 1'b0;
      r_dbz_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // Start wins over a simultaneous mthi/mtlo.
            r_op  <= i_op;
            r_a   <= w_abs_a;
            r_b   <= w_abs_b;
            r_sa  <= w_signed_in & i_operand_a[31];
            r_sb  <= w_signed_in & i_operand_b[31];
            r_cnt <= 5'd31;
            r_acc <= {32'd0, w_abs_b};
            r_rem <= 33'd0;
            r_quo <= w_abs_a;
            if (i_op[1] && (i_operand_b == 32'd0)) begin
              r_dbz      <= 1'b1;
              r_fix_wait <= 1'b1;
              r_state    <= S_FIXUP;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= i_op[1] ? S_DIV : S_MUL;
            end
          end else begin
            if (i_write_hi) r_hi <= i_write_data;
            if (i_write_lo) r_lo <= i_write_data;
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[31:1]};
          if (r_cnt == 5'd0) r_state <= S_FIXUP;
          else               r_cnt   <= r_cnt - 5'd1;
        end
        S_DIV: begin
          if (!w_trial[33]) begin
            r_rem <= w_trial[32:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_shifted;
            r_quo <= {r_quo[30:0], 1'b0};
          end
          if (r_cnt == 5'd0) r_state <= S_FIXUP;
          else               r_cnt   <= r_cnt - 5'd1;
        end
        default: begin // S_FIXUP
          if (r_fix_wait) begin
            // Divide-by-zero holds one extra cycle so it commits at E0+2.
            r_fix_wait <= 1'b0;
          end else begin
            if (r_dbz) begin
              r_hi       <= r_a;
              r_lo       <= 32'hFFFF_FFFF;
              r_dbz_flag <= 1'b1;
            end else if (r_op[1]) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[63:32];
              r_lo <= w_prod_fix[31:0];
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_busy        = (r_state != S_IDLE);
  assign o_stall       = o_busy & (i_start | i_hi_read | i_lo_read | i_write_hi | i_write_lo);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz_flag;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed and random stimulus for muldiv_sequencer. Expected HI/LO values
//   come from plain 64-bit integer arithmetic on the architectural operands.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        hi_read = 1'b0;
  logic        lo_read = 1'b0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dbz;

  int checks = 0;
  int failures = 0;
  logic [31:0] e_hi = 32'd0;
  logic [31:0] e_lo = 32'd0;

  muldiv_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_operand_a(opa), .i_operand_b(opb),
    .i_hi_read(hi_read), .i_lo_read(lo_read),
    .i_write_hi(wr_hi), .i_write_lo(wr_lo), .i_write_data(wdata),
    .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_stall(stall),
    .o_done(done), .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result {div_by_zero, HI, LO}.
  function automatic logic [64:0] model(input logic [1:0] m_op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (m_op)
      2'd0: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'd0) return {1'b1, (a[31] ? 32'(-sa) : a), 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issue one operation and check every cycle up to the commit. Returns in
  // the Done cycle so a following call issues its Start during Done.
  // rd_from >= 0 holds mfhi + mthi from edge E0+rd_from up to the commit.
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                        input int rd_from, input bit wr_with_start);
    logic [64:0] m;
    int lat;
    m   = model(t_op, a, b);
    lat = (t_op[1] && b == 32'd0) ? 2 : 33;
    @(negedge clk);
    start = 1'b1; op = t_op; opa = a; opb = b;
    if (wr_with_start) begin wr_hi = 1'b1; wr_lo = 1'b1; wdata = ~e_hi; end
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (rd_from >= 0 && k >= rd_from) begin hi_read = 1'b1; wr_hi = 1'b1; wdata = ~e_hi; end
      @(posedge clk); #1;
      if (k < lat) begin
        check("busy_during_op", busy, 1);
        check("done_during_op", done, 0);
        check("hi_held", hi, e_hi);
        check("lo_held", lo, e_lo);
        check("stall_during_op", stall, hi_read | wr_hi);
      end
    end
    check("commit_hi", hi, m[63:32]);
    check("commit_lo", lo, m[31:0]);
    check("commit_done", done, 1);
    check("commit_dbz", dbz, m[64]);
    check("commit_idle", busy, 0);
    check("commit_stall", stall, 0);
    hi_read = 1'b0; wr_hi = 1'b0;
    e_hi = m[63:32];
    e_lo = m[31:0];
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] ra, rb;
    int sel;

    // Reset state, with pipeline requests present.
    start = 1'b1; hi_read = 1'b1;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    check("rst_stall", stall, 0);
    start = 1'b0; hi_read = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Directed examples; consecutive calls also start in the Done cycle.
    run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, -1, 1'b0);
    run_op(2'd3, 32'h1234_5678, 32'd0, -1, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
    // mfhi/mthi held while busy: stall until commit, HI untouched.
    run_op(2'd1, 32'hCAFE_F00D, 32'h1357_9BDF, 5, 1'b0);
    // Start with mthi/mtlo in IDLE: the write is dropped.
    run_op(2'd0, 32'h0000_1234, 32'hFFFF_FF00, -1, 1'b1);

    // mthi / mtlo in IDLE.
    @(negedge clk); wr_hi = 1'b1; wdata = 32'hA5A5_0001;
    @(posedge clk); #1; wr_hi = 1'b0; e_hi = 32'hA5A5_0001;
    check("mthi_hi", hi, e_hi);
    check("mthi_lo", lo, e_lo);
    check("done_cleared", done, 0);
    @(negedge clk); wr_lo = 1'b1; wdata = 32'h5A5A_0002;
    @(posedge clk); #1; wr_lo = 1'b0; e_lo = 32'h5A5A_0002;
    check("mtlo_lo", lo, e_lo);
    check("mtlo_hi", hi, e_hi);

    // Reset in the middle of a MULTU.
    @(negedge clk); start = 1'b1; op = 2'd1; opa = 32'h0000_DEAD; opb = 32'h0000_0077;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0; hi_read = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_stall", stall, 0);
    check("midrst_done", done, 0);
    e_hi = 32'd0; e_lo = 32'd0;
    @(negedge clk); rst_n = 1'b1; hi_read = 1'b0;
    run_op(2'd1, 32'd3, 32'd5, -1, 1'b0);

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      sel  = $urandom_range(0, 7);
      if (sel == 0) begin rb = 32'd0; r_op = 2'd3; end
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) ra = 32'($urandom_range(0, 255));
      run_op(r_op, ra, rb, -1, 1'b0);
    end

    @(posedge clk); #1;
    check("final_done_low", done, 0);
    check("final_dbz_low", dbz, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
